// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
// FSM state encoding and default widths.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  localparam int SEL_W_DEF = 3;
  localparam int HOLD_W    = 4;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Scan sequencer bus: select/sample path to the mux,
// start request and valid/ready result handshake.
interface mux_scan_sequencer_if #(
  parameter int SEL_W = 3
);
  localparam int N_CH = 2 ** SEL_W;

  logic             start;
  logic [SEL_W-1:0] sel;
  logic             mux_out;
  logic             busy;
  logic [N_CH-1:0]  data;
  logic             data_valid;
  logic             data_ready;

  modport master (
    input  start,
    input  mux_out,
    input  data_ready,
    output sel,
    output busy,
    output data,
    output data_valid
  );

  modport slave (
    output start,
    output mux_out,
    output data_ready,
    input  sel,
    input  busy,
    input  data,
    input  data_valid
  );

endinterface

// File: rtl/multiplexer.sv
// Combinational 2**SEL_W:1 bit multiplexer.
// Scanned channel by channel by mux_scan_sequencer.
module multiplexer #(
  parameter int SEL_W = 3
) (
  input  logic [2**SEL_W-1:0] in,
  input  logic [SEL_W-1:0]    sel,
  output logic                out
);

  assign out = in[sel];

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the mux select over every channel, settles,
// samples each bit and hands the word downstream.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SEL_W       = SEL_W_DEF,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_scan_sequencer_if.master bus
);

  localparam int N_CH = 2 ** SEL_W;

  localparam logic [HOLD_W-1:0] RELOAD =
    HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  localparam bit ZERO_HOLD = (HOLD_CYCLES == 0);

  localparam state_t NEXT_CH =
    ZERO_HOLD ? CAPTURE : SETTLE;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [N_CH-1:0]   data_q, data_d;

  // Next-state: scan FSM, settle counter, select and capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sel_d   = '0;
          busy_d  = 1'b1;
          cnt_d   = RELOAD;
          state_d = NEXT_CH;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      CAPTURE: begin
        data_d[sel_q] = bus.mux_out;
        sel_d         = sel_q + SEL_W'(1);
        if (sel_q == LAST) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = RELOAD;
          state_d = NEXT_CH;
        end
      end
      DONE: begin
        if (bus.data_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.busy       = busy_q;
  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer driving
// a multiplexer; hold=1 and hold=0 instances.
module tb_mux_scan_sequencer;

  localparam int NCH = 8;
  localparam int H0  = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in0;
  logic [7:0] in1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_scan_sequencer_if #(.SEL_W(3)) bus0 ();
  mux_scan_sequencer_if #(.SEL_W(3)) bus1 ();

  multiplexer #(.SEL_W(3)) mux0 (
    .in  (in0),
    .sel (bus0.sel),
    .out (bus0.mux_out)
  );

  multiplexer #(.SEL_W(3)) mux1 (
    .in  (in1),
    .sel (bus1.sel),
    .out (bus1.mux_out)
  );

  mux_scan_sequencer #(
    .SEL_W       (3),
    .HOLD_CYCLES (1)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  mux_scan_sequencer #(
    .SEL_W       (3),
    .HOLD_CYCLES (0)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Full scan on the hold=1 instance. Expected word is
  // built from the input value present at each channel's
  // sample edge E0+(k+1)*(H+1).
  task automatic run_scan0(
    input logic [7:0] in_a,
    input logic [7:0] in_b,
    input int         chg,
    input int         rd,
    input bit         poke,
    input string      name
  );
    int         len;
    int         k;
    logic [7:0] exp_w;
    logic [4:0] got;
    logic [4:0] want;
    len   = NCH * (H0 + 1);
    exp_w = '0;
    @(negedge clk);
    bus0.start      = 1'b1;
    bus0.data_ready = 1'b0;
    in0             = in_a;
    @(posedge clk);
    for (int c = 0; c <= len + rd + 1; c++) begin
      @(negedge clk);
      bus0.start = 1'b0;
      got = {bus0.busy, bus0.data_valid, bus0.sel};
      if (c < len) begin
        want = {1'b1, 1'b0, 3'(c / (H0 + 1))};
      end else if (c <= len + rd) begin
        want = {1'b0, 1'b1, 3'd0};
      end else begin
        want = {1'b0, 1'b0, 3'd0};
      end
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s ctl c=%0d got %b want %b",
                 name, c, got, want);
      end
      if (c >= len) begin
        n_tests++;
        if (bus0.data !== exp_w) begin
          n_fail++;
          $display("FAIL %s data c=%0d got %h want %h",
                   name, c, bus0.data, exp_w);
        end
        if (poke && c <= len + rd) bus0.start = 1'b1;
        if (c == len + rd) bus0.data_ready = 1'b1;
      end
      if (c == chg) in0 = in_b;
      if (c < len + rd + 1) begin
        @(posedge clk);
        if ((c + 1) % (H0 + 1) == 0 && c + 1 <= len) begin
          k = (c + 1) / (H0 + 1) - 1;
          exp_w[k] = in0[k];
        end
      end
    end
    bus0.start      = 1'b0;
    bus0.data_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus0.busy !== 1'b0 || bus0.data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after busy=%b valid=%b want 0 0",
               name, bus0.busy, bus0.data_valid);
    end
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus0.start      = 1'b1;
    bus1.start      = 1'b1;
    bus0.data_ready = 1'b0;
    bus1.data_ready = 1'b0;
    in0             = 8'hFF;
    in1             = 8'hFF;
    repeat (4) begin
      @(negedge clk);
      n_tests++;
      if ({bus0.busy, bus0.data_valid, bus0.sel,
           bus0.data} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset0 got %b %b %h %h want 0",
                 bus0.busy, bus0.data_valid,
                 bus0.sel, bus0.data);
      end
      n_tests++;
      if ({bus1.busy, bus1.data_valid, bus1.sel,
           bus1.data} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset1 got %b %b %h %h want 0",
                 bus1.busy, bus1.data_valid,
                 bus1.sel, bus1.data);
      end
    end
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (bus0.busy !== 1'b0 || bus1.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release busy got %b %b want 0 0",
                 bus0.busy, bus1.busy);
      end
    end
  endtask

  task automatic test_default_scan();
    run_scan0(8'h55, 8'h55, -1, 0, 1'b0, "default");
    n_tests++;
    if (bus0.data !== 8'h55) begin
      n_fail++;
      $display("FAIL default_word got %h want 55", bus0.data);
    end
  endtask

  task automatic test_backpressure();
    run_scan0(8'h55, 8'h55, -1, 5, 1'b1, "backpressure");
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (bus0.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_nostart busy=%b want 0",
                 bus0.busy);
      end
    end
  endtask

  task automatic test_mid_change();
    run_scan0(8'hFF, 8'h00, 8, 0, 1'b0, "mid_change");
    n_tests++;
    if (bus0.data !== 8'h0F) begin
      n_fail++;
      $display("FAIL mid_change_word got %h want 0f",
               bus0.data);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in0        = 8'hFF;
    bus0.start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus0.start = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (bus0.sel !== 3'd5 || bus0.data === 8'h00) begin
      n_fail++;
      $display("FAIL async_pre sel=%0d data=%h want 5 nonzero",
               bus0.sel, bus0.data);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus0.busy, bus0.data_valid, bus0.sel,
         bus0.data} !== 13'd0) begin
      n_fail++;
      $display("FAIL async_reset got %b %b %0d %h want 0",
               bus0.busy, bus0.data_valid,
               bus0.sel, bus0.data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_scan0(8'h3C, 8'h3C, -1, 0, 1'b0, "after_reset");
    n_tests++;
    if (bus0.data !== 8'h3C) begin
      n_fail++;
      $display("FAIL after_reset_word got %h want 3c",
               bus0.data);
    end
  endtask

  task automatic test_zero_hold();
    logic [4:0] want;
    @(negedge clk);
    in1             = 8'hA5;
    bus1.start      = 1'b1;
    bus1.data_ready = 1'b0;
    @(posedge clk);
    for (int c = 0; c <= NCH; c++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      want = (c < NCH) ? {1'b1, 1'b0, 3'(c)}
                       : {1'b0, 1'b1, 3'd0};
      n_tests++;
      if ({bus1.busy, bus1.data_valid, bus1.sel} !== want) begin
        n_fail++;
        $display("FAIL zero_hold c=%0d got %b%b%0d want %b",
                 c, bus1.busy, bus1.data_valid,
                 bus1.sel, want);
      end
      if (c == NCH) begin
        n_tests++;
        if (bus1.data !== 8'hA5) begin
          n_fail++;
          $display("FAIL zero_hold_word got %h want a5",
                   bus1.data);
        end
        bus1.data_ready = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus1.data_ready = 1'b0;
    n_tests++;
    if (bus1.data_valid !== 1'b0 || bus1.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_hold_idle valid=%b busy=%b want 0 0",
               bus1.data_valid, bus1.busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    int         chg;
    int         rd;
    bit         poke;
    for (int i = 0; i < 8; i++) begin
      a    = 8'($urandom);
      b    = 8'($urandom);
      chg  = int'($urandom_range(0, 15));
      rd   = int'($urandom_range(0, 3));
      poke = 1'($urandom_range(0, 1));
      run_scan0(a, b, chg, rd, poke, "random");
    end
  endtask

  initial begin
    test_reset();
    test_default_scan();
    test_backpressure();
    test_mid_change();
    test_async_reset();
    test_zero_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Upstream controller for the 8:1 `multiplexer` stage. On a start pulse it drives the multiplexer select through every channel in order. It waits a programmable number of settle cycles on each channel, then samples the multiplexer output bit. The result is an N_CH-bit parallel word, presented downstream with a valid/ready handshake, so a single-bit mux path becomes a registered parallel capture of all inputs.

## Interface
Parameters:
- `SEL_W`, 3, select width; must match the multiplexer's `sel` width.
- `N_CH`, 2**SEL_W (8), channel count; derived, not overridden.
- `HOLD_CYCLES`, 1, settle cycles on each channel before sampling; legal range 0..15.

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  scan request; sampled only in IDLE.
- `sel`  out  SEL_W  select to the multiplexer; registered.
- `mux_out`  in  1  the multiplexer's `out`.
- `busy`  out  1  high in SETTLE and CAPTURE.
- `data`  out  N_CH  captured word; `data[k]` is the bit sampled with `sel==k`.
- `data_valid`  out  1  high in DONE.
- `data_ready`  in  1  downstream accept.

## Operation
- States:
  - IDLE: wait for `start`.
  - SETTLE: count `HOLD_CYCLES` cycles on the current channel.
  - CAPTURE: sample `mux_out` into `data[sel]`.
  - DONE: hold the word with `data_valid` high.
- IDLE with `start`=1:
  - Set `sel`<=0 and `busy`<=1.
  - If `HOLD_CYCLES`>0, go to SETTLE with the counter loaded to `HOLD_CYCLES`-1; otherwise go directly to CAPTURE.
- SETTLE: decrement the counter each cycle. When the counter is 0, go to CAPTURE.
- CAPTURE (one cycle):
  - At the ending edge, `data[sel]`<=`mux_out`.
  - If `sel`==N_CH-1: `sel` wraps to 0 by natural SEL_W-bit increment, go to DONE.
  - Otherwise: `sel`<=`sel`+1, reload the counter, go to SETTLE, or stay in CAPTURE if `HOLD_CYCLES`==0.
- DONE:
  - `data` and `sel`(=0) are frozen.
  - `data_valid`&&`data_ready` at an edge returns the block to IDLE.
- `start` outside IDLE is ignored, including in the DONE handshake cycle. A new scan needs `start` while in IDLE.
- `data` is overwritten bit by bit during a scan and is meaningful only while `data_valid`=1. In IDLE it holds the last word.
- Reset (asynchronous, at any time, including mid-scan):
  - Immediately `sel`=0, `busy`=0, `data_valid`=0, `data`=0, state IDLE, counter 0.
  - After release, the first `start` begins a clean scan.

## Timing
- Let E0 be the edge that samples `start` in IDLE.
- `busy` and `sel`=0 are visible after E0.
- Channel k is sampled at edge E0+(k+1)·(HOLD_CYCLES+1).
- `sel`=k is stable for HOLD_CYCLES+1 cycles before its sample edge. This is the settle margin for the combinational mux path.
- The last capture is at E0+N_CH·(HOLD_CYCLES+1). At that edge `busy` falls and `data_valid` rises. Defaults: E16. With HOLD_CYCLES=0: E8.
- Handshake: `data_valid` drops on the edge after the cycle where `data_ready`=1. The minimum DONE dwell is 1 cycle, when `data_ready` is already high.
- Scan period, start to start: N_CH·(HOLD_CYCLES+1)+2 cycles minimum.

## Structure
- Shared package `mux_scan_pkg`:
  - `state_t` enum {IDLE, SETTLE, CAPTURE, DONE}.
  - Constants `SEL_W_DEF`=3 and `HOLD_W`=4 (counter width).
- No sub-module: the FSM, settle counter, select register and capture register are inline.
- The bench instantiates the existing `multiplexer` between `sel`/`mux_out` and an 8-bit `in` stimulus.

## Test plan
- Reset: hold `rst_n`=0 with `start`=1 → `sel`=0, `busy`=0, `data_valid`=0, `data`=8'h00; nothing starts until release.
- Default scan:
  - Stimulus: `in`=8'b01010101, `HOLD_CYCLES`=1, one-cycle `start` pulse.
  - `sel` steps 0..7, two cycles each; `data_valid` rises at E16 with `data`=8'h55.
  - With `data_ready`=1, the block is back in IDLE at E17.
- Backpressure:
  - Stimulus: hold `data_ready`=0 for 5 cycles in DONE and pulse `start` during that time.
  - `data`=8'h55 and `data_valid`=1 stay stable, `sel`=0, and `start` is ignored.
  - After `data_ready`=1, `data_valid`=0 on the next edge.
- Mid-scan input change:
  - Stimulus: `in`=8'hFF, then change to 8'h00 while `sel`=4 is settling.
  - Result: `data`=8'h0F. Bits 0–3 were captured before the change; bits 4–7 see the new value.
- Asynchronous reset mid-scan:
  - Stimulus: drop `rst_n` between edges at `sel`=5.
  - `busy`, `sel` and `data` go to 0 without a clock edge.
  - After release and a new `start` with `in`=8'h3C, `data`=8'h3C.
- Zero hold:
  - Stimulus: `HOLD_CYCLES`=0, `in`=8'hA5, `start`.
  - `sel` advances every cycle; `data_valid` rises at E8 with `data`=8'hA5; `sel` wraps to 0.
